// File: rtl/mfp_ahb_arbiter.sv
// mfp_ahb_arbiter: two-master AHB-Lite arbiter with hold-count fairness.
// Master 0 is the core and master 1 is a secondary requester (loader/DMA).
// Optional macro MFP_AHB_ARB_LOCK_EN enables locked sequences (HLOCK/HMASTLOCK).
module mfp_ahb_arbiter #(
    parameter int unsigned HOLD_MAX       = 4,
    parameter int unsigned DEFAULT_MASTER = 0
) (
    input  logic        HCLK,
    input  logic        SI_Reset,
    input  logic        M0_HBUSREQ,
    input  logic        M0_HLOCK,
    output logic        M0_HGRANT,
    input  logic [31:0] M0_HADDR,
    input  logic [1:0]  M0_HTRANS,
    input  logic        M0_HWRITE,
    input  logic [2:0]  M0_HSIZE,
    input  logic [2:0]  M0_HBURST,
    input  logic [31:0] M0_HWDATA,
    input  logic        M1_HBUSREQ,
    input  logic        M1_HLOCK,
    output logic        M1_HGRANT,
    input  logic [31:0] M1_HADDR,
    input  logic [1:0]  M1_HTRANS,
    input  logic        M1_HWRITE,
    input  logic [2:0]  M1_HSIZE,
    input  logic [2:0]  M1_HBURST,
    input  logic [31:0] M1_HWDATA,
    input  logic        HREADY,
    output logic [31:0] S_HADDR,
    output logic [1:0]  S_HTRANS,
    output logic        S_HWRITE,
    output logic [2:0]  S_HSIZE,
    output logic [2:0]  S_HBURST,
    output logic [31:0] S_HWDATA,
    output logic        S_HMASTLOCK,
    output logic        HMASTER
);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [3:0] HOLD_LIMIT    = 4'(HOLD_MAX);
    localparam logic [3:0] HOLD_SAT      = 4'hF;
    localparam logic       DEF_MST       = 1'(DEFAULT_MASTER);

    logic       hgrant_q, hgrant_d;
    logic       hmaster_q, hmaster_d;
    logic       hdata_mst_q, hdata_mst_d;
    logic [3:0] hold_cnt_q, hold_cnt_d;

    logic [1:0] own_trans;
    logic [2:0] own_burst;
    logic       own_lock;
    logic       req_own;
    logic       req_oth;
    logic       arb_point;

`ifdef MFP_AHB_ARB_LOCK_EN
    logic       lock_q, lock_d;
`else
    logic       unused_lock;
    assign unused_lock = M0_HLOCK ^ M1_HLOCK;
`endif

    // Address/control follow the address-phase owner, write data the data-phase owner
    always_comb begin
        S_HADDR   = hmaster_q   ? M1_HADDR   : M0_HADDR;
        S_HTRANS  = hmaster_q   ? M1_HTRANS  : M0_HTRANS;
        S_HWRITE  = hmaster_q   ? M1_HWRITE  : M0_HWRITE;
        S_HSIZE   = hmaster_q   ? M1_HSIZE   : M0_HSIZE;
        S_HBURST  = hmaster_q   ? M1_HBURST  : M0_HBURST;
        S_HWDATA  = hdata_mst_q ? M1_HWDATA  : M0_HWDATA;
        M0_HGRANT = ~hgrant_q;
        M1_HGRANT = hgrant_q;
        HMASTER   = hmaster_q;
`ifdef MFP_AHB_ARB_LOCK_EN
        S_HMASTLOCK = lock_q;
`else
        S_HMASTLOCK = 1'b0;
`endif
    end

    // Next-state: ownership pipeline, fairness counter and grant decision
    always_comb begin
        hgrant_d    = hgrant_q;
        hmaster_d   = hmaster_q;
        hdata_mst_d = hdata_mst_q;
        hold_cnt_d  = hold_cnt_q;
        own_trans   = hmaster_q ? M1_HTRANS : M0_HTRANS;
        own_burst   = hmaster_q ? M1_HBURST : M0_HBURST;
        req_own     = hgrant_q  ? M1_HBUSREQ : M0_HBUSREQ;
        req_oth     = hgrant_q  ? M0_HBUSREQ : M1_HBUSREQ;
`ifdef MFP_AHB_ARB_LOCK_EN
        own_lock    = hmaster_q ? M1_HLOCK : M0_HLOCK;
        lock_d      = lock_q;
`else
        own_lock    = 1'b0;
`endif
        // Only IDLE or a NONSEQ SINGLE lets the bus change hands (bursts run to the end)
        arb_point = (hgrant_q == hmaster_q) && !own_lock &&
                    ((own_trans == HTRANS_IDLE) ||
                     ((own_trans == HTRANS_NONSEQ) && (own_burst == HBURST_SINGLE)));

        if (HREADY) begin
            hdata_mst_d = hmaster_q;
            hmaster_d   = hgrant_q;
`ifdef MFP_AHB_ARB_LOCK_EN
            lock_d      = hgrant_q ? M1_HLOCK : M0_HLOCK;
`endif
            if (hgrant_q != hmaster_q) begin
                hold_cnt_d = 4'd0;
            end else if (own_trans[1] && (hold_cnt_q != HOLD_SAT)) begin
                hold_cnt_d = hold_cnt_q + 4'd1;
            end

            if (arb_point) begin
                if (req_oth && (!req_own || (hold_cnt_q >= HOLD_LIMIT))) begin
                    hgrant_d = ~hgrant_q;
                end else if (!req_oth && !req_own) begin
                    hgrant_d = DEF_MST;
                end
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge HCLK) begin
        if (SI_Reset) begin
            hgrant_q    <= DEF_MST;
            hmaster_q   <= DEF_MST;
            hdata_mst_q <= DEF_MST;
            hold_cnt_q  <= 4'd0;
`ifdef MFP_AHB_ARB_LOCK_EN
            lock_q      <= 1'b0;
`endif
        end else begin
            hgrant_q    <= hgrant_d;
            hmaster_q   <= hmaster_d;
            hdata_mst_q <= hdata_mst_d;
            hold_cnt_q  <= hold_cnt_d;
`ifdef MFP_AHB_ARB_LOCK_EN
            lock_q      <= lock_d;
`endif
        end
    end

endmodule

// File: tb/tb_mfp_ahb_arbiter.sv
// Testbench for mfp_ahb_arbiter: directed vector table, lock sequence and
// randomized traffic checked against a behavioural model.
module tb_mfp_ahb_arbiter;

    localparam int HOLD_MAX = 4;
    localparam int DEF_M    = 0;

    logic        HCLK;
    logic        rst;
    logic        rdy;
    logic        rq [2];
    logic        lk [2];
    logic [31:0] addr [2];
    logic [1:0]  tr [2];
    logic        wr [2];
    logic [2:0]  sz [2];
    logic [2:0]  bu [2];
    logic [31:0] wd [2];

    logic        g0, g1, hm, mlock, s_wr;
    logic [31:0] s_addr, s_wd;
    logic [1:0]  s_tr;
    logic [2:0]  s_sz, s_bu;

    int checks   = 0;
    int failures = 0;

    // behavioural model state
    int m_grant, m_owner, m_down, m_hold;
    bit m_lock;
    bit m_valid = 0;

    typedef struct {
        logic       rst, rdy, rq0, rq1;
        logic [1:0] tr0;
        logic [2:0] bu0;
        logic [1:0] tr1;
        logic [2:0] bu1;
        logic       g1, hm;
    } vec_t;

    vec_t tbl[$];

    mfp_ahb_arbiter #(.HOLD_MAX(HOLD_MAX), .DEFAULT_MASTER(DEF_M)) dut (
        .HCLK(HCLK), .SI_Reset(rst),
        .M0_HBUSREQ(rq[0]), .M0_HLOCK(lk[0]), .M0_HGRANT(g0),
        .M0_HADDR(addr[0]), .M0_HTRANS(tr[0]), .M0_HWRITE(wr[0]),
        .M0_HSIZE(sz[0]), .M0_HBURST(bu[0]), .M0_HWDATA(wd[0]),
        .M1_HBUSREQ(rq[1]), .M1_HLOCK(lk[1]), .M1_HGRANT(g1),
        .M1_HADDR(addr[1]), .M1_HTRANS(tr[1]), .M1_HWRITE(wr[1]),
        .M1_HSIZE(sz[1]), .M1_HBURST(bu[1]), .M1_HWDATA(wd[1]),
        .HREADY(rdy),
        .S_HADDR(s_addr), .S_HTRANS(s_tr), .S_HWRITE(s_wr), .S_HSIZE(s_sz),
        .S_HBURST(s_bu), .S_HWDATA(s_wd), .S_HMASTLOCK(mlock), .HMASTER(hm)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    function automatic vec_t row(logic r, logic y, logic q0, logic q1,
                                 logic [1:0] t0, logic [2:0] b0,
                                 logic [1:0] t1, logic [2:0] b1,
                                 logic eg1, logic ehm);
        vec_t v;
        v.rst = r; v.rdy = y; v.rq0 = q0; v.rq1 = q1;
        v.tr0 = t0; v.bu0 = b0; v.tr1 = t1; v.bu1 = b1;
        v.g1 = eg1; v.hm = ehm;
        return v;
    endfunction

    task automatic rand_data();
        for (int m = 0; m < 2; m++) begin
            addr[m] = $urandom;
            wd[m]   = $urandom;
            wr[m]   = 1'($urandom_range(0, 1));
            sz[m]   = 3'($urandom_range(0, 2));
        end
    endtask

    // Reference: applies the arbitration rules for one clock edge
    task automatic model_edge();
        int  o, n, ng, nh;
        bit  handover, arb;
        if (rst) begin
            m_grant = DEF_M; m_owner = DEF_M; m_down = DEF_M;
            m_hold = 0; m_lock = 0; m_valid = 1;
            return;
        end
        if (!rdy || !m_valid) return;
        o = m_grant;
        n = 1 - o;
        handover = (m_grant != m_owner);
        arb = !handover && (tr[m_owner] == 2'b00 ||
                            (tr[m_owner] == 2'b10 && bu[m_owner] == 3'b000));
`ifdef MFP_AHB_ARB_LOCK_EN
        if (lk[m_owner]) arb = 0;
`endif
        ng = m_grant;
        if (arb) begin
            if (rq[n] && (!rq[o] || m_hold >= HOLD_MAX)) ng = n;
            else if (!rq[0] && !rq[1]) ng = DEF_M;
        end
        if (handover) nh = 0;
        else if (tr[m_owner] == 2'b10 || tr[m_owner] == 2'b11) nh = (m_hold >= 15) ? 15 : m_hold + 1;
        else nh = m_hold;
`ifdef MFP_AHB_ARB_LOCK_EN
        m_lock = lk[m_grant];
`endif
        m_down  = m_owner;
        m_owner = m_grant;
        m_grant = ng;
        m_hold  = nh;
    endtask

    task automatic check_model();
        logic [76:0] exp_v, act_v;
        logic        el;
        if (!m_valid) return;
`ifdef MFP_AHB_ARB_LOCK_EN
        el = m_lock;
`else
        el = 1'b0;
`endif
        exp_v = {m_grant == 0, m_grant == 1, 1'(m_owner), addr[m_owner], tr[m_owner],
                 wr[m_owner], sz[m_owner], bu[m_owner], wd[m_down], el};
        act_v = {g0, g1, hm, s_addr, s_tr, s_wr, s_sz, s_bu, s_wd, mlock};
        checks++;
        if (act_v !== exp_v) begin
            failures++;
            if (failures < 30)
                $display("FAIL model t=%0t got=%h expected=%h", $time, act_v, exp_v);
        end
    endtask

    // One cycle: inputs already applied; check, advance model, cross the edge
    task automatic step();
        #1;
        check_model();
        model_edge();
        @(posedge HCLK);
        #1;
    endtask

    task automatic check_bit(string name, logic act, logic exp_b);
        checks++;
        if (act !== exp_b) begin
            failures++;
            $display("FAIL %s t=%0t got=%b expected=%b", name, $time, act, exp_b);
        end
    endtask

    initial begin
        rst = 1; rdy = 1;
        for (int m = 0; m < 2; m++) begin
            rq[m] = 0; lk[m] = 0; tr[m] = 2'b00; bu[m] = 3'b000;
        end
        rand_data();

        // reset, handover, fairness both ways, wait states, burst hold, reset mid-transfer
        tbl.push_back(row(1,1,0,0,2'b00,3'd0,2'b00,3'd0, 0,0));
        tbl.push_back(row(1,1,0,0,2'b00,3'd0,2'b00,3'd0, 0,0));
        tbl.push_back(row(0,1,0,1,2'b00,3'd0,2'b00,3'd0, 1,0));
        tbl.push_back(row(0,1,0,1,2'b00,3'd0,2'b00,3'd0, 1,1));
        tbl.push_back(row(0,1,0,1,2'b00,3'd0,2'b00,3'd0, 1,1));
        for (int i = 0; i < 4; i++)
            tbl.push_back(row(0,1,1,1,2'b00,3'd0,2'b10,3'd0, 1,1));
        tbl.push_back(row(0,1,1,1,2'b00,3'd0,2'b10,3'd0, 0,1));
        tbl.push_back(row(0,1,1,1,2'b10,3'd0,2'b10,3'd0, 0,0));
        for (int i = 0; i < 4; i++)
            tbl.push_back(row(0,1,1,1,2'b10,3'd0,2'b00,3'd0, 0,0));
        tbl.push_back(row(0,1,1,1,2'b10,3'd0,2'b00,3'd0, 1,0));
        for (int i = 0; i < 3; i++)
            tbl.push_back(row(0,0,1,1,2'b10,3'd0,2'b00,3'd0, 1,0));
        tbl.push_back(row(0,1,1,1,2'b10,3'd0,2'b00,3'd0, 1,1));
        tbl.push_back(row(0,1,1,0,2'b00,3'd0,2'b00,3'd0, 0,1));
        tbl.push_back(row(0,1,1,0,2'b00,3'd0,2'b00,3'd0, 0,0));
        tbl.push_back(row(0,1,1,0,2'b10,3'd2,2'b00,3'd0, 0,0));
        for (int i = 0; i < 3; i++)
            tbl.push_back(row(0,1,1,1,2'b11,3'd2,2'b00,3'd0, 0,0));
        tbl.push_back(row(0,1,0,1,2'b00,3'd2,2'b00,3'd0, 1,0));
        tbl.push_back(row(0,1,0,1,2'b00,3'd0,2'b00,3'd0, 1,1));
        tbl.push_back(row(1,0,0,1,2'b10,3'd0,2'b10,3'd0, 0,0));

        @(posedge HCLK);
        #1;
        for (int i = 0; i < tbl.size(); i++) begin
            rst = tbl[i].rst; rdy = tbl[i].rdy;
            rq[0] = tbl[i].rq0; rq[1] = tbl[i].rq1;
            tr[0] = tbl[i].tr0; bu[0] = tbl[i].bu0;
            tr[1] = tbl[i].tr1; bu[1] = tbl[i].bu1;
            rand_data();
            step();
            check_bit($sformatf("vec%0d_grant1", i), g1, tbl[i].g1);
            check_bit($sformatf("vec%0d_hmaster", i), hm, tbl[i].hm);
        end

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            for (int m = 0; m < 2; m++) begin
                rq[m] = ($urandom_range(0, 3) != 0);
                lk[m] = ($urandom_range(0, 3) == 0);
                tr[m] = 2'($urandom_range(0, 3));
                bu[m] = ($urandom_range(0, 1) == 0) ? 3'b000 : 3'($urandom_range(0, 7));
            end
            rand_data();
            step();
        end

        // Locked sequence: M0 holds lock over 10 NONSEQ SINGLE transfers, M1 requesting
        rst = 1; rdy = 1;
        for (int m = 0; m < 2; m++) begin
            rq[m] = 0; lk[m] = 0; tr[m] = 2'b00; bu[m] = 3'b000;
        end
        step();
        step();
        rst = 0; rq[0] = 1; rq[1] = 1; lk[0] = 1; tr[0] = 2'b10;
        for (int i = 0; i < 10; i++) begin
            rand_data();
            step();
`ifdef MFP_AHB_ARB_LOCK_EN
            check_bit($sformatf("lock%0d_grant1", i), g1, 1'b0);
            check_bit($sformatf("lock%0d_mastlock", i), mlock, 1'b1);
`else
            check_bit($sformatf("lock%0d_grant1", i), g1, (i >= 4) ? 1'b1 : 1'b0);
            check_bit($sformatf("lock%0d_mastlock", i), mlock, 1'b0);
`endif
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
